// File: rtl/hwag_angle_ch_if.sv
// Register write bus for the HWAG angle channel block.
// master drives writes (CPU side / bench), slave is the channel block.
`timescale 1ns/1ps
interface hwag_angle_ch_if #(
  parameter int CH_NUM    = 4,
  parameter int ANG_WIDTH = 12
) ();
  localparam int AW = $clog2(CH_NUM) + 2;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [ANG_WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/hwag_angle_ch.sv
// Multi-channel crank-angle window generator driven by the HWAG angle counter.
// Each channel drives ch_out high inside [set, reset) on the 0..ANG_TOP scale;
// window angles are double-buffered and transfer at the angle wrap.
// Optional macro HWAG_CH_IRQ_EN adds per-channel rise flags and an irq output.
//
// state | meaning
// IDLE  | HWAG not synchronized or channel disabled, output low
// WAIT  | tracking angle, outside window, output low
// ON    | angle inside window, output high
`timescale 1ns/1ps
module hwag_angle_ch #(
  parameter int CH_NUM    = 4,
  parameter int ANG_WIDTH = 12,
  parameter int ANG_TOP   = 3839
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hwag_start,
  input  logic [23:0]         acnt_in,
  hwag_angle_ch_if.slave      bus,
  output logic [CH_NUM-1:0]   ch_out,
  output logic [2*CH_NUM-1:0] ch_state
`ifdef HWAG_CH_IRQ_EN
  ,
  output logic [CH_NUM-1:0]   irq_flags,
  input  logic [CH_NUM-1:0]   irq_clr,
  output logic                irq
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ON = 2'd2} state_t;

  // Written angles above the last valid angle are clamped so a bad write
  // cannot create a window edge the counter never reaches.
  localparam logic [ANG_WIDTH-1:0] ANG_MAX = ANG_WIDTH'(ANG_TOP);

  logic [ANG_WIDTH-1:0] pend_set [CH_NUM];
  logic [ANG_WIDTH-1:0] pend_rst [CH_NUM];
  logic [ANG_WIDTH-1:0] act_set  [CH_NUM];
  logic [ANG_WIDTH-1:0] act_rst  [CH_NUM];
  logic [ANG_WIDTH-1:0] eff_set  [CH_NUM];
  logic [ANG_WIDTH-1:0] eff_rst  [CH_NUM];
  state_t               state    [CH_NUM];
  logic [CH_NUM-1:0]    en;
  logic [23:0]          acnt_d;

  logic                 step;
  logic                 wrap;
  int                   wr_ch;
  logic [ANG_WIDTH-1:0] wr_ang;
  logic [CH_NUM-1:0]    wr_set, wr_rst, wr_ctl;
  logic [CH_NUM-1:0]    en_nxt, xfer, in_win;

  // Step/wrap detect, write decode and wrap-aware window test per channel.
  always_comb begin
    step   = hwag_start && (acnt_in != acnt_d);
    wrap   = step && (acnt_in < acnt_d);
    wr_ch  = int'(bus.wr_addr >> 2);
    wr_ang = (bus.wr_data > ANG_MAX) ? ANG_MAX : bus.wr_data;
    wr_set = '0;
    wr_rst = '0;
    wr_ctl = '0;
    en_nxt = '0;
    xfer   = '0;
    in_win = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      wr_set[c] = bus.wr_en && (wr_ch == c) && (bus.wr_addr[1:0] == 2'd0);
      wr_rst[c] = bus.wr_en && (wr_ch == c) && (bus.wr_addr[1:0] == 2'd1);
      wr_ctl[c] = bus.wr_en && (wr_ch == c) && (bus.wr_addr[1:0] == 2'd2);
      en_nxt[c] = wr_ctl[c] ? bus.wr_data[0] : en[c];
      xfer[c]   = wrap || !hwag_start || !en[c];
      // The window test in a transfer cycle already sees the new angles.
      eff_set[c] = xfer[c] ? pend_set[c] : act_set[c];
      eff_rst[c] = xfer[c] ? pend_rst[c] : act_rst[c];
      if (eff_set[c] < eff_rst[c])
        in_win[c] = (acnt_in >= 24'(eff_set[c])) && (acnt_in < 24'(eff_rst[c]));
      else if (eff_set[c] > eff_rst[c])
        in_win[c] = (acnt_in >= 24'(eff_set[c])) || (acnt_in < 24'(eff_rst[c]));
      else
        in_win[c] = 1'b0;
    end
  end

  // Registers, double-buffer transfer and per-channel state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acnt_d <= '0;
      en     <= '0;
      ch_out <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        pend_set[c] <= '0;
        pend_rst[c] <= '0;
        act_set[c]  <= '0;
        act_rst[c]  <= '0;
        state[c]    <= IDLE;
      end
`ifdef HWAG_CH_IRQ_EN
      irq_flags <= '0;
`endif
    end else begin
      acnt_d <= acnt_in;
      for (int c = 0; c < CH_NUM; c++) begin
        if (wr_set[c]) pend_set[c] <= wr_ang;
        if (wr_rst[c]) pend_rst[c] <= wr_ang;
        if (wr_ctl[c]) en[c] <= bus.wr_data[0];
        if (xfer[c]) begin
          act_set[c] <= pend_set[c];
          act_rst[c] <= pend_rst[c];
        end
`ifdef HWAG_CH_IRQ_EN
        if (irq_clr[c]) irq_flags[c] <= 1'b0;
`endif
        if (!hwag_start || !en_nxt[c]) begin
          state[c]  <= IDLE;
          ch_out[c] <= 1'b0;
        end else begin
          case (state[c])
            IDLE: if (!step) state[c] <= WAIT;
            WAIT: if (step && in_win[c]) begin
              state[c]  <= ON;
              ch_out[c] <= 1'b1;
`ifdef HWAG_CH_IRQ_EN
              irq_flags[c] <= 1'b1;
`endif
            end
            ON: if (step && !in_win[c]) begin
              state[c]  <= WAIT;
              ch_out[c] <= 1'b0;
            end
            default: begin
              state[c]  <= IDLE;
              ch_out[c] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Pack per-channel state codes for debug.
  always_comb begin
    ch_state = '0;
    for (int c = 0; c < CH_NUM; c++) ch_state[2*c +: 2] = state[c];
  end

`ifdef HWAG_CH_IRQ_EN
  assign irq = |irq_flags;
`endif

endmodule

// File: tb/tb_hwag_angle_ch.sv
// Self-checking bench for hwag_angle_ch: revolution sweeps with a window
// model, a vector table for jumps/start/enable/buffering corners, and
// hand sequences for async reset and the optional interrupt flags.
`timescale 1ns/1ps
module tb_hwag_angle_ch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hwag_start = 1'b0;
  logic [23:0] acnt_in = '0;
  logic [3:0]  ch_out;
  logic [7:0]  ch_state;
`ifdef HWAG_CH_IRQ_EN
  logic [3:0]  irq_flags;
  logic [3:0]  irq_clr = '0;
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  hwag_angle_ch_if #(.CH_NUM(4), .ANG_WIDTH(12)) bus ();

  hwag_angle_ch #(.CH_NUM(4), .ANG_WIDTH(12), .ANG_TOP(3839)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt_in    (acnt_in),
    .bus        (bus),
    .ch_out     (ch_out),
    .ch_state   (ch_state)
`ifdef HWAG_CH_IRQ_EN
    ,
    .irq_flags  (irq_flags),
    .irq_clr    (irq_clr),
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs;
    int         acnt;
    logic       we;
    int         waddr;
    int         wdata;
    logic [3:0] out;
    logic [7:0] st;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic [7:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(ch * 4 + sel);
    bus.wr_data = 12'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Vector with ch0 expectations; other channels are disabled in the table.
  task automatic add(input logic hs, input int acnt, input logic we, input int waddr,
                     input int wdata, input logic out0, input int st0);
    vec_t v;
    v.hs = hs; v.acnt = acnt; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.out = {3'b000, out0};
    v.st  = {6'b0, 2'(st0)};
    vecs.push_back(v);
  endtask

  function automatic bit win(input int s, input int r, input int a);
    if (s < r) return (a >= s) && (a < r);
    if (s > r) return (a >= s) || (a < r);
    return 1'b0;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    int   set0, rst0, set1, rst1;
    bit   stepped, w0, w1;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    // Reset state
    tick(); tick();
    check("rst_ch_out", 16'(ch_out), 16'h0);
    check("rst_ch_state", 16'(ch_state), 16'h0);
`ifdef HWAG_CH_IRQ_EN
    check("rst_irq_flags", 16'(irq_flags), 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
`endif
    rst = 1'b1;
    tick();

    // Configure ch0 [100,300) and ch1 [3800,50) with the angle counter idle.
    wr(0, 0, 100); wr(0, 1, 300); wr(0, 2, 1);
    wr(1, 0, 3800); wr(1, 1, 50); wr(1, 2, 1);
    tick();
    check("cfg_idle_out", 16'(ch_out), 16'h0);

    // Three revolutions, 4 clk per step; ch0 rewritten to [500,600) mid-pulse.
    set0 = 100; rst0 = 300; set1 = 3800; rst1 = 50;
    hwag_start = 1'b1;
    for (int rev = 0; rev < 3; rev++) begin
      for (int a = 0; a <= 3839; a++) begin
        acnt_in = 24'(a);
        if (rev == 2 && a == 0) begin set0 = 500; rst0 = 600; end
        for (int k = 0; k < 4; k++) begin
          bus.wr_en = 1'b0;
          if (rev == 1 && a == 200 && k < 2) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(k);
            bus.wr_data = (k == 0) ? 12'd500 : 12'd600;
          end
          stepped = !(rev == 0 && a == 0);
          w0 = stepped && win(set0, rst0, a);
          w1 = stepped && win(set1, rst1, a);
          e.out = {2'b00, w1, w0};
          e.st  = {4'b0, (w1 ? 2'd2 : 2'd1), (w0 ? 2'd2 : 2'd1)};
          sb.push_back(e);
          tick();
          e = sb.pop_front();
          check($sformatf("sweep_r%0d_a%0d_out", rev, a), 16'(ch_out), 16'(e.out));
          if (k == 0)
            check($sformatf("sweep_r%0d_a%0d_st", rev, a), 16'(ch_state), 16'(e.st));
        end
      end
    end
    bus.wr_en = 1'b0;

    // Table: ch0 only, window [100,300), ch1 disabled.
    hwag_start = 1'b0;
    wr(0, 0, 100); wr(0, 1, 300); wr(1, 2, 0);
    tick();
    check("pre_table_out", 16'(ch_out), 16'h0);

    add(1,   90, 0, 0,   0, 0, 0);  // wrap jump from 3839: step keeps IDLE
    add(1,   90, 0, 0,   0, 0, 1);
    add(1,  128, 0, 0,   0, 1, 2);  // reload jump across set
    add(1,  129, 0, 0,   0, 1, 2);
    add(0,  129, 0, 0,   0, 0, 0);  // start falls while ON
    add(0,  200, 0, 0,   0, 0, 0);
    add(1,  200, 0, 0,   0, 0, 1);  // restart inside window
    add(1,  201, 0, 0,   0, 1, 2);  // ON at next step
    add(1,  300, 0, 0,   0, 0, 1);  // reset edge
    add(0,  300, 1, 0, 100, 0, 0);
    add(0,  300, 1, 1, 120, 0, 0);
    add(0,   90, 0, 0,   0, 0, 0);  // transfers [100,120)
    add(1,   90, 0, 0,   0, 0, 1);
    add(1,  128, 0, 0,   0, 0, 1);  // jump across whole window
    add(1,  129, 0, 0,   0, 0, 1);
    add(1,  110, 0, 0,   0, 1, 2);
    add(1,  110, 1, 2,   0, 0, 0);  // enable cleared while ON
    add(1,  110, 1, 2,   1, 0, 1);
    add(1,  111, 1, 3,   0, 1, 2);  // reserved sel ignored
    add(1,  112, 0, 0,   0, 1, 2);
    add(1,  112, 1, 0,   5, 1, 2);  // pending only
    add(1,  112, 1, 1,  10, 1, 2);
    add(1,  130, 0, 0,   0, 0, 1);  // old window still active
    add(1,    7, 0, 0,   0, 1, 2);  // wrap uses new [5,10)
    add(1,    7, 1, 1,  20, 1, 2);
    add(1,    3, 1, 0,   2, 0, 1);  // write during transfer stays pending
    add(1,    1, 0, 0,   0, 0, 1);
    add(1,    0, 0, 0,   0, 0, 1);
    add(1,    2, 0, 0,   0, 1, 2);  // set=2 now active
    add(0,    2, 1, 0,  50, 0, 0);
    add(0,    2, 1, 1,  50, 0, 0);
    add(0,    2, 0, 0,   0, 0, 0);
    add(1,    2, 0, 0,   0, 0, 1);
    add(1,   50, 0, 0,   0, 0, 1);  // empty window
    add(1,   51, 0, 0,   0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      hwag_start  = v.hs;
      acnt_in     = 24'(v.acnt);
      bus.wr_en   = v.we;
      bus.wr_addr = 4'(v.waddr);
      bus.wr_data = 12'(v.wdata);
      e.out = v.out;
      e.st  = v.st;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_out", i), 16'(ch_out), 16'(e.out));
      check($sformatf("vec%0d_state", i), 16'(ch_state), 16'(e.st));
    end
    bus.wr_en = 1'b0;

    // Asynchronous reset in the middle of a pulse.
    hwag_start = 1'b0;
    acnt_in = 24'd2;
    wr(0, 0, 10); wr(0, 1, 40);
    tick();
    hwag_start = 1'b1;
    tick();
    acnt_in = 24'd20;
    tick();
    check("pre_rst_on", 16'(ch_out), 16'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", 16'(ch_out), 16'h0);
    check("async_rst_state", 16'(ch_state), 16'h0);
    tick();
    rst = 1'b1;
    tick();

`ifdef HWAG_CH_IRQ_EN
    check("irq_after_rst", 16'(irq), 16'h0);
    hwag_start = 1'b0;
    acnt_in = 24'd2;
    wr(2, 0, 10); wr(2, 1, 40); wr(2, 2, 1);
    tick();
    hwag_start = 1'b1;
    tick();
    acnt_in = 24'd20;
    tick();
    check("irq_rise_out", 16'(ch_out), 16'h4);
    check("irq_rise_flags", 16'(irq_flags), 16'h4);
    check("irq_rise_irq", 16'(irq), 16'h1);
    acnt_in = 24'd50;
    tick();
    irq_clr = 4'b0100;
    tick();
    irq_clr = 4'b0000;
    check("irq_clr_flags", 16'(irq_flags), 16'h0);
    check("irq_clr_irq", 16'(irq), 16'h0);
    acnt_in = 24'd15;
    irq_clr = 4'b0100;
    tick();
    irq_clr = 4'b0000;
    check("irq_set_wins_flags", 16'(irq_flags), 16'h4);
    check("irq_set_wins_irq", 16'(irq), 16'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
